// File: rtl/alu_pipe_core_if.sv
// Handshaked operand/result bundle for alu_pipe_core: producer side drives
// operands and out_ready, the ALU (slave) drives in_ready and the result bundle.
interface alu_pipe_core_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             binvert;
  logic             carryin;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;

  modport master (
    output in_valid, a, b, binvert, carryin, op, out_ready,
    input  in_ready, out_valid, result, carryout, zero
  );

  modport slave (
    input  in_valid, a, b, binvert, carryin, op, out_ready,
    output in_ready, out_valid, result, carryout, zero
  );
endinterface

// File: rtl/alu_pipe_core.sv
// Registered, valid/ready handshaked ALU (AND/OR/ADD/SLT, optional MUL).
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for op 100.
module alu_pipe_core #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  alu_pipe_core_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam int         CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`endif

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [WIDTH-1:0] result_r;
  logic             carryout_r;
  logic             zero_r;
  logic             accept_s;
  logic             in_ready_s;
  logic             load_s;
  logic [WIDTH-1:0] res_nx_s;
  logic             cout_nx_s;
  logic [WIDTH-1:0] bx_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             slt_ovf_s;
  logic             slt_lt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_cout_s;

  assign in_ready_s    = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && bus.out_ready);
  assign accept_s      = bus.in_valid && in_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == ST_HOLD);
  assign bus.result    = result_r;
  assign bus.carryout  = carryout_r;
  assign bus.zero      = zero_r;

  assign bx_s   = bus.binvert ? ~bus.b : bus.b;
  assign sum_s  = {1'b0, bus.a} + {1'b0, bx_s} + {{WIDTH{1'b0}}, bus.carryin};
  assign diff_s = bus.a + ~bus.b + {{(WIDTH-1){1'b0}}, 1'b1};
  // Signed less-than: sign of a-b, corrected when the subtraction overflows
  assign slt_ovf_s = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (diff_s[WIDTH-1] ^ bus.a[WIDTH-1]);
  assign slt_lt_s  = diff_s[WIDTH-1] ^ slt_ovf_s;

  // Single-cycle op result; reserved codes (and MUL here) yield zero
  always_comb begin
    alu_res_s  = {WIDTH{1'b0}};
    alu_cout_s = 1'b0;
    case (bus.op)
      OP_AND: alu_res_s = bus.a & bx_s;
      OP_OR:  alu_res_s = bus.a | bx_s;
      OP_ADD: begin
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
      end
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, slt_lt_s};
      default: begin
        alu_res_s  = {WIDTH{1'b0}};
        alu_cout_s = 1'b0;
      end
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_nx_s;

  // One shift-add step: low half holds unconsumed multiplier bits, high half accumulates
  always_comb begin
    mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    prod_nx_s = {mul_sum_s, prod_r[WIDTH-1:1]};
  end

  // Multiplier operand, product and iteration counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r <= {WIDTH{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s && (bus.op == OP_MUL)) begin
      mcand_r <= bus.a;
      prod_r  <= {{WIDTH{1'b0}}, bus.b};
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_MUL) begin
      prod_r  <= prod_nx_s;
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      mcand_r <= mcand_r;
      prod_r  <= prod_r;
      cnt_r   <= cnt_r;
    end
  end
`endif

  // Next state and selection of the value loaded into the result registers
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    res_nx_s   = alu_res_s;
    cout_nx_s  = alu_cout_s;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (accept_s) begin
`ifdef ALU_PIPE_MUL_EN
          if (bus.op == OP_MUL) begin
            state_nx_s = ST_MUL;
          end else begin
            state_nx_s = ST_HOLD;
            load_s     = 1'b1;
          end
`else
          state_nx_s = ST_HOLD;
          load_s     = 1'b1;
`endif
        end else if ((state_r == ST_HOLD) && bus.out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      ST_MUL: begin
        if (cnt_r == CW'(WIDTH-1)) begin
          state_nx_s = ST_HOLD;
          load_s     = 1'b1;
          res_nx_s   = prod_nx_s[WIDTH-1:0];
          cout_nx_s  = |prod_nx_s[2*WIDTH-1:WIDTH];
        end else begin
          state_nx_s = ST_MUL;
        end
      end
`endif
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register and result/carryout/zero output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      result_r   <= {WIDTH{1'b0}};
      carryout_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (load_s) begin
        result_r   <= res_nx_s;
        carryout_r <= cout_nx_s;
        zero_r     <= (res_nx_s == {WIDTH{1'b0}});
      end else begin
        result_r   <= result_r;
        carryout_r <= carryout_r;
        zero_r     <= zero_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed self-checking bench for alu_pipe_core (WIDTH=32); MUL scenarios
// are exercised when ALU_PIPE_MUL_EN is defined, reserved-op behaviour otherwise.
module tb_alu_pipe_core;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;

  alu_pipe_core_if #(.WIDTH(32)) bus ();

  alu_pipe_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic bi, input logic ci);
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.binvert  = bi;
    bus.carryin  = ci;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.carryout !== 1'b0 || bus.zero !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus.carryout, bus.zero); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    drive(1'b1, 3'b010, 32'd5, 32'd3, 1'b0, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b want=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.result !== 32'd8) begin bad++; $display("FAIL add_result got=%h want=%h", bus.result, 32'd8); end
    total++; if (bus.carryout !== 1'b0 || bus.zero !== 1'b0) begin bad++; $display("FAIL add_flags got=%b%b want=00", bus.carryout, bus.zero); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL add_hold_in_ready got=%b want=1", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_idle_out_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b010, 32'd3, 32'd5, 1'b1, 1'b1);
    step();
    total++; if (bus.result !== 32'hFFFF_FFFE || bus.carryout !== 1'b0) begin bad++; $display("FAIL sub_neg got=%h/%b want=fffffffe/0", bus.result, bus.carryout); end
    drive(1'b1, 3'b010, 32'd5, 32'd3, 1'b1, 1'b1);
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd2 || bus.carryout !== 1'b1) begin bad++; $display("FAIL sub_pos got=%b/%h/%b want=1/00000002/1", bus.out_valid, bus.result, bus.carryout); end
    drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    step();
    total++; if (bus.result !== 32'd1 || bus.zero !== 1'b0 || bus.carryout !== 1'b0) begin bad++; $display("FAIL slt_neg got=%h/%b/%b want=00000001/0/0", bus.result, bus.zero, bus.carryout); end
    drive(1'b1, 3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    step();
    total++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin bad++; $display("FAIL slt_ovf got=%h/%b want=00000000/1", bus.result, bus.zero); end
    drive(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    step();
    total++; if (bus.result !== 32'd0 || bus.carryout !== 1'b1 || bus.zero !== 1'b1) begin bad++; $display("FAIL add_wrap got=%h/%b/%b want=00000000/1/1", bus.result, bus.carryout, bus.zero); end
    drive(1'b1, 3'b000, 32'hFFFF_00FF, 32'h0F0F_0F0F, 1'b1, 1'b0);
    step();
    total++; if (bus.result !== 32'hF0F0_00F0) begin bad++; $display("FAIL and_binv got=%h want=f0f000f0", bus.result); end
    drive(1'b1, 3'b001, 32'h0000_0011, 32'h1200_0000, 1'b0, 1'b1);
    step();
    total++; if (bus.result !== 32'h1200_0011 || bus.carryout !== 1'b0) begin bad++; $display("FAIL or_plain got=%h/%b want=12000011/0", bus.result, bus.carryout); end
    drive(1'b1, 3'b110, 32'd9, 32'd9, 1'b0, 1'b1);
    step();
    total++; if (bus.result !== 32'd0 || bus.carryout !== 1'b0 || bus.zero !== 1'b1) begin bad++; $display("FAIL reserved got=%h/%b/%b want=00000000/0/1", bus.result, bus.carryout, bus.zero); end
    bus.in_valid = 1'b0;
    step();
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    drive(1'b1, 3'b100, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mul_busy_in_ready cycle=%0d got=%b want=0", n, bus.in_ready); end
      step();
      n++;
    end
    total++; if (n !== 32) begin bad++; $display("FAIL mul_latency got=%0d want=32", n); end
    total++; if (bus.result !== 32'd0 || bus.carryout !== 1'b1 || bus.zero !== 1'b1) begin bad++; $display("FAIL mul_ovf got=%h/%b/%b want=00000000/1/1", bus.result, bus.carryout, bus.zero); end
    drive(1'b1, 3'b100, 32'd7, 32'd6, 1'b1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    total++; if (n !== 32) begin bad++; $display("FAIL mul2_latency got=%0d want=32", n); end
    total++; if (bus.result !== 32'd42 || bus.carryout !== 1'b0 || bus.zero !== 1'b0) begin bad++; $display("FAIL mul_small got=%h/%b/%b want=0000002a/0/0", bus.result, bus.carryout, bus.zero); end
    step();
  endtask
`else
  task automatic test_mul();
    drive(1'b1, 3'b100, 32'd7, 32'd6, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mul_off_latency got=%b want=1", bus.out_valid); end
    total++; if (bus.result !== 32'd0 || bus.carryout !== 1'b0 || bus.zero !== 1'b1) begin bad++; $display("FAIL mul_off_result got=%h/%b/%b want=00000000/0/1", bus.result, bus.carryout, bus.zero); end
    step();
  endtask
`endif

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hF000_F000 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold cycle=%0d got=%b/%h/%b want=1/f000f000/0", i, bus.out_valid, bus.result, bus.in_ready); end
      bus.in_valid = (i == 2);
      step();
    end
    total++; if (bus.result !== 32'hF000_F000) begin bad++; $display("FAIL bp_ignored_bundle got=%h want=f000f000", bus.result); end
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b001, 32'd1, 32'd2, 1'b0, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd3) begin bad++; $display("FAIL bp_new_bundle got=%b/%h want=1/00000003", bus.out_valid, bus.result); end
    step();
  endtask

  task automatic test_reset_abort();
`ifdef ALU_PIPE_MUL_EN
    drive(1'b1, 3'b100, 32'd7, 32'd6, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
`else
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b010, 32'd7, 32'd6, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step();
`endif
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.carryout !== 1'b0 || bus.zero !== 1'b0) begin bad++; $display("FAIL abort_async got=%b/%h/%b/%b want=0/00000000/0/0", bus.out_valid, bus.result, bus.carryout, bus.zero); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) rst = 1'b0;
      step();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_result cycle=%0d got=%b want=0", i, bus.out_valid); end
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b want=1", bus.in_ready); end
    drive(1'b1, 3'b010, 32'd1, 32'd1, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd2 || bus.carryout !== 1'b0) begin bad++; $display("FAIL abort_fresh_add got=%b/%h/%b want=1/00000002/0", bus.out_valid, bus.result, bus.carryout); end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
